cpu_board_display: RTL and testbench

CPU_BOARD_DISPLAY -- requirements
Module: cpu_board_display

---
 rtl/cpu_board_display.sv | 140 ++++++++++++++
 tb/tb_cpu_board_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_board_display.sv
// Board front-end for a single-step CPU: debounced step clock, press
// counter and a four-digit multiplexed hex display of CPU state.
module cpu_board_display #(
    parameter int DB_CNT   = 1000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        step_btn,
    input  logic [1:0]  sw_sel,
    input  logic [31:0] curPC,
    input  logic [31:0] nextPC,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] ALUResult,
    input  logic [31:0] DB,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        cpu_clk,
    output logic [7:0]  step_cnt,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DB_CNT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] db_cnt;
    logic [PW-1:0] pre;
    logic [1:0]    digit;
    logic [15:0]   frame;
    logic [15:0]   frame_next;
    logic          scan_tick;
    logic          frame_wrap;
    logic          accept;
    logic [3:0]    nibble;
    logic [7:0]    hex;
    logic          unused_bits;

    assign unused_bits = ^{curPC[31:8], nextPC[31:8],
                           ReadData1[31:8], ReadData2[31:8],
                           ALUResult[31:8], DB[31:8]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
        end
    end

    assign accept = (sync2 != level) && (db_cnt == C_LAST);

    // Any cycle the input agrees with the accepted level restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level    <= 1'b0;
            db_cnt   <= '0;
            step_cnt <= 8'd0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (accept) begin
            level  <= ~level;
            db_cnt <= '0;
            if (!level)
                step_cnt <= step_cnt + 8'd1;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign cpu_clk = level;

    assign scan_tick  = (pre == P_LAST);
    assign frame_wrap = scan_tick && (digit == 2'd3);

    always_comb begin
        frame_next = 16'h0000;
        case (sw_sel)
            2'b00:   frame_next = {curPC[7:0], nextPC[7:0]};
            2'b01:   frame_next = {3'b000, rs, ReadData1[7:0]};
            2'b10:   frame_next = {3'b000, rt, ReadData2[7:0]};
            default: frame_next = {ALUResult[7:0], DB[7:0]};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre   <= '0;
            digit <= 2'd0;
            frame <= 16'h0000;
        end else begin
            pre <= scan_tick ? '0 : pre + 1'b1;
            if (scan_tick)
                digit <= digit + 2'd1;
            if (frame_wrap)
                frame <= frame_next;
        end
    end

    assign nibble = frame[{digit, 2'b00} +: 4];

    always_comb begin
        hex = 8'hFF;
        case (nibble)
            4'h0: hex = 8'hC0;
            4'h1: hex = 8'hF9;
            4'h2: hex = 8'hA4;
            4'h3: hex = 8'hB0;
            4'h4: hex = 8'h99;
            4'h5: hex = 8'h92;
            4'h6: hex = 8'h82;
            4'h7: hex = 8'hF8;
            4'h8: hex = 8'h80;
            4'h9: hex = 8'h90;
            4'hA: hex = 8'h88;
            4'hB: hex = 8'h83;
            4'hC: hex = 8'hC6;
            4'hD: hex = 8'hA1;
            4'hE: hex = 8'h86;
            default: hex = 8'h8E;
        endcase
    end

    // Decimal point on digit 2 separates the two displayed bytes.
    always_comb begin
        an  = ~(4'b0001 << digit);
        seg = hex;
        if (digit == 2'd2)
            seg[7] = 1'b0;
    end

endmodule

// File: tb/tb_cpu_board_display.sv
// Directed bench for cpu_board_display with DB_CNT=4, SCAN_DIV=2:
// frame vector table plus debounce, reset and wrap sequences.
module tb_cpu_board_display;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        step_btn = 1'b0;
    logic [1:0]  sw_sel = 2'b00;
    logic [31:0] curPC = '0;
    logic [31:0] nextPC = '0;
    logic [31:0] ReadData1 = '0;
    logic [31:0] ReadData2 = '0;
    logic [31:0] ALUResult = '0;
    logic [31:0] DB = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic        cpu_clk;
    logic [7:0]  step_cnt;
    logic [3:0]  an;
    logic [7:0]  seg;

    int n_vec = 0;
    int n_err = 0;

    cpu_board_display #(.DB_CNT(4), .SCAN_DIV(2)) dut (
        .CLK(CLK), .RST(RST), .step_btn(step_btn),
        .sw_sel(sw_sel), .curPC(curPC), .nextPC(nextPC),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ALUResult(ALUResult), .DB(DB), .rs(rs), .rt(rt),
        .cpu_clk(cpu_clk), .step_cnt(step_cnt),
        .an(an), .seg(seg)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [7:0]  s3;
    } vec_t;

    vec_t tbl[5];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    task automatic chk_digit(input string nm, input logic [3:0] ea,
                             input logic [7:0] es);
        chk({nm, "_an"}, {28'd0, an}, {28'd0, ea});
        chk({nm, "_seg"}, {24'd0, seg}, {24'd0, es});
    endtask

    task automatic set_frame(input vec_t v);
        sw_sel = v.sel;
        curPC = '0; nextPC = '0; ReadData1 = '0;
        ReadData2 = '0; ALUResult = '0; DB = '0;
        rs = '0; rt = '0;
        case (v.sel)
            2'b00: begin curPC = v.a; nextPC = v.b; end
            2'b01: begin rs = v.r; ReadData1 = v.b; end
            2'b10: begin rt = v.r; ReadData2 = v.b; end
            default: begin ALUResult = v.a; DB = v.b; end
        endcase
    endtask

    initial begin
        tbl[0] = '{2'b00, 32'h14, 32'h18, 5'h00,
                   8'h80, 8'hF9, 8'h19, 8'hF9};
        tbl[1] = '{2'b01, 32'h00, 32'hFFFF_FFAB, 5'h1F,
                   8'h83, 8'h88, 8'h0E, 8'hF9};
        tbl[2] = '{2'b10, 32'h00, 32'h0000_123D, 5'h0C,
                   8'hA1, 8'hB0, 8'h46, 8'hC0};
        tbl[3] = '{2'b11, 32'hABCD_0027, 32'h5555_556E, 5'h00,
                   8'h86, 8'h82, 8'h78, 8'hA4};
        tbl[4] = '{2'b00, 32'h0000_0059, 32'h0000_0090, 5'h00,
                   8'hC0, 8'h90, 8'h10, 8'h92};

        tick(2);
        do_reset();
        chk("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
        chk("rst_step_cnt", {24'd0, step_cnt}, 32'd0);
        chk_digit("rst", 4'b1110, 8'hC0);

        for (int v = 0; v < 5; v++) begin
            set_frame(tbl[v]);
            do_reset();
            chk_digit($sformatf("v%0d_rst", v), 4'b1110, 8'hC0);
            tick(8);
            chk_digit($sformatf("v%0d_d0", v), 4'b1110, tbl[v].s0);
            tick(2);
            chk_digit($sformatf("v%0d_d1", v), 4'b1101, tbl[v].s1);
            tick(2);
            chk_digit($sformatf("v%0d_d2", v), 4'b1011, tbl[v].s2);
            tick(2);
            chk_digit($sformatf("v%0d_d3", v), 4'b0111, tbl[v].s3);
        end

        set_frame(tbl[0]);
        do_reset();
        tick(10);
        sw_sel = 2'b11;
        ALUResult = 32'h27;
        DB = 32'h6E;
        tick(1);
        chk_digit("hold_d1", 4'b1101, 8'hF9);
        tick(1);
        chk_digit("hold_d2", 4'b1011, 8'h19);
        tick(2);
        chk_digit("hold_d3", 4'b0111, 8'hF9);
        tick(2);
        chk_digit("new_d0", 4'b1110, 8'h86);
        tick(2);
        chk_digit("new_d1", 4'b1101, 8'h82);
        tick(2);
        chk_digit("new_d2", 4'b1011, 8'h78);
        tick(2);
        chk_digit("new_d3", 4'b0111, 8'hA4);

        do_reset();
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk($sformatf("press_t%0d", i), {31'd0, cpu_clk},
                {31'd0, (i >= 6)});
        end
        chk("press_cnt", {24'd0, step_cnt}, 32'd1);
        step_btn = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk($sformatf("rel_t%0d", i), {31'd0, cpu_clk},
                {31'd0, (i < 6)});
        end
        chk("rel_cnt", {24'd0, step_cnt}, 32'd1);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            step_btn = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                chk("bounce_hi", {31'd0, cpu_clk}, 32'd0);
            end
            step_btn = 1'b0;
            tick(1);
            chk("bounce_lo", {31'd0, cpu_clk}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("bounce_idle", {31'd0, cpu_clk}, 32'd0);
        end
        chk("bounce_cnt", {24'd0, step_cnt}, 32'd0);

        do_reset();
        step_btn = 1'b1;
        tick(5);
        chk("mid_pre", {31'd0, cpu_clk}, 32'd0);
        do_reset();
        chk("mid_rst_clk", {31'd0, cpu_clk}, 32'd0);
        chk("mid_rst_cnt", {24'd0, step_cnt}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            chk($sformatf("mid_t%0d", i), {31'd0, cpu_clk},
                {31'd0, (i >= 6)});
        end
        chk("mid_cnt", {24'd0, step_cnt}, 32'd1);

        step_btn = 1'b0;
        tick(7);
        for (int p = 0; p < 255; p++) begin
            step_btn = 1'b1;
            tick(7);
            step_btn = 1'b0;
            tick(7);
        end
        chk("wrap_cnt", {24'd0, step_cnt}, 32'd0);
        chk("wrap_clk", {31'd0, cpu_clk}, 32'd0);
        step_btn = 1'b1;
        tick(7);
        chk("wrap_next", {24'd0, step_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
